// File: rtl/alu_ctrl.sv
// ----------------------------------------------------------------------------
// alu_ctrl
//
// Command sequencer sitting in front of a combinational 4-bit ALU. It holds a
// 4 x 4-bit register file and accepts one command at a time. A command is
// either an immediate load or an ALU operation. ALU results are written back
// truncated to 4 bits, and the full 5-bit result is returned as a response.
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   synchronous, active-high reset
//   cmd_valid    in   command present
//   cmd_ready    out  controller can accept a command (IDLE and not in reset)
//   cmd_ld       in   1 = load cmd_imm into cmd_rd, 0 = ALU operation
//   cmd_op       in   [3:0] ALU opcode, forwarded unchanged to alu_op
//   cmd_ra/rb    in   [1:0] source register indices
//   cmd_rd       in   [1:0] destination register index
//   cmd_imm      in   [3:0] immediate for loads
//   alu_a/alu_b  out  [3:0] ALU operands, latched at command acceptance
//   alu_op       out  [3:0] ALU opcode, latched at command acceptance
//   alu_result   in   [4:0] combinational ALU result
//   rsp_valid    out  response present
//   rsp_ready    in   requester accepts the response
//   rsp_data     out  [4:0] result of the command
//   flag         out  sticky carry/compare bit
//
// Configuration
//   ALU_CTRL_FLAG_EN  when defined, flag is a register loaded with
//                     alu_result[4] on every ALU-command write-back (loads
//                     leave it unchanged). When undefined, flag is tied to 0.
// ----------------------------------------------------------------------------
module alu_ctrl (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic       cmd_ld,
   input  logic [3:0] cmd_op,
   input  logic [1:0] cmd_ra,
   input  logic [1:0] cmd_rb,
   input  logic [1:0] cmd_rd,
   input  logic [3:0] cmd_imm,
   output logic [3:0] alu_a,
   output logic [3:0] alu_b,
   output logic [3:0] alu_op,
   input  logic [4:0] alu_result,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic [4:0] rsp_data,
   output logic       flag
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } state_t;

   state_t     state;
   state_t     state_nxt;

   logic [3:0] rf [4];
   logic       ld_q;
   logic [1:0] rd_q;
   logic [3:0] imm_q;
   logic       cmd_accept;

   assign cmd_accept = cmd_valid & cmd_ready;

   // State register.
   // NOTE: sequential state is assigned with <= so every flop samples the
   // pre-edge values of its inputs regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic.
   always_comb begin
      // NOTE: default assignment first so no path leaves state_nxt unassigned
      // (which would infer a latch).
      state_nxt = state;
      unique case (state)
         IDLE:    if (cmd_accept) state_nxt = ISSUE;
         ISSUE:   state_nxt = RESP;
         RESP:    if (rsp_ready)  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Handshake outputs. cmd_ready is masked by rst so nothing is accepted on
   // the reset edge itself.
   always_comb begin
      cmd_ready = (state == IDLE) && !rst;
      rsp_valid = (state == RESP);
   end

   // Operand latch, register file write-back and response register.
   // Operands are captured at acceptance, so a source equal to rd sees the
   // pre-write value.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: the register file is small and must read back zero after
         // reset, so it is reset explicitly like the other state.
         for (int i = 0; i < 4; i++) begin
            rf[i] <= 4'd0;
         end
         alu_a    <= 4'd0;
         alu_b    <= 4'd0;
         alu_op   <= 4'd0;
         ld_q     <= 1'b0;
         rd_q     <= 2'd0;
         imm_q    <= 4'd0;
         rsp_data <= 5'd0;
      end else begin
         if (cmd_accept) begin
            alu_a  <= rf[cmd_ra];
            alu_b  <= rf[cmd_rb];
            alu_op <= cmd_op;
            ld_q   <= cmd_ld;
            rd_q   <= cmd_rd;
            imm_q  <= cmd_imm;
         end
         if (state == ISSUE) begin
            if (ld_q) begin
               rf[rd_q] <= imm_q;
               rsp_data <= {1'b0, imm_q};
            end else begin
               rf[rd_q] <= alu_result[3:0];
               rsp_data <= alu_result;
            end
         end
      end
   end

`ifdef ALU_CTRL_FLAG_EN
   logic flag_q;

   // Carry/borrow or compare outcome of the most recent ALU command.
   always_ff @(posedge clk) begin
      if (rst) begin
         flag_q <= 1'b0;
      end else if ((state == ISSUE) && !ld_q) begin
         flag_q <= alu_result[4];
      end
   end

   assign flag = flag_q;
`else
   assign flag = 1'b0;
`endif

endmodule

// File: tb/tb_alu_ctrl.sv
// ----------------------------------------------------------------------------
// tb_alu_ctrl
//
// Self-checking bench for alu_ctrl. A small combinational ALU stub drives
// alu_result from the DUT's alu_a/alu_b/alu_op. A transaction-level model
// tracks the register file and the expected outputs; a compare process checks
// every DUT output against it on each falling edge. Directed sequences pin the
// model with hand-computed literals, then randomized traffic (including
// random resets and backpressure) exercises the rest.
// Build with +define+ALU_CTRL_FLAG_EN to check the flag-enabled variant.
// ----------------------------------------------------------------------------
module tb_alu_ctrl;

`ifdef ALU_CTRL_FLAG_EN
   localparam bit FLAG_EN = 1'b1;
`else
   localparam bit FLAG_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic       cmd_ld = 1'b0;
   logic [3:0] cmd_op = 4'd0;
   logic [1:0] cmd_ra = 2'd0;
   logic [1:0] cmd_rb = 2'd0;
   logic [1:0] cmd_rd = 2'd0;
   logic [3:0] cmd_imm = 4'd0;
   logic [3:0] alu_a;
   logic [3:0] alu_b;
   logic [3:0] alu_op;
   logic [4:0] alu_result;
   logic       rsp_valid;
   logic       rsp_ready = 1'b0;
   logic [4:0] rsp_data;
   logic       flag;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   alu_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_ld     (cmd_ld),
      .cmd_op     (cmd_op),
      .cmd_ra     (cmd_ra),
      .cmd_rb     (cmd_rb),
      .cmd_rd     (cmd_rd),
      .cmd_imm    (cmd_imm),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_op     (alu_op),
      .alu_result (alu_result),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_data   (rsp_data),
      .flag       (flag)
   );

   // Stand-in for the combinational ALU: add, sub, inc, dec, equal, greater,
   // and an arbitrary mixing function for the remaining opcodes.
   function automatic logic [4:0] alu_fn(input logic [3:0] a, input logic [3:0] b,
                                         input logic [3:0] op);
      case (op)
         4'b0000: return {1'b0, a} + {1'b0, b};
         4'b0001: return {1'b0, a} - {1'b0, b};
         4'b0010: return {1'b0, a} + 5'd1;
         4'b0011: return {1'b0, a} - 5'd1;
         4'b1100: return {4'd0, (a == b)};
         4'b1111: return {4'd0, (a > b)};
         default: return {op[0], a ^ b ^ op};
      endcase
   endfunction

   assign alu_result = alu_fn(alu_a, alu_b, alu_op);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------------
   // Transaction model. m_phase counts where the current command is:
   // 0 = none in flight, 1 = accepted last edge (operands on the ALU),
   // 2 = result available and waiting for the requester.
   // ------------------------------------------------------------------------
   logic [3:0] m_rf [4];
   logic [3:0] m_a = 4'd0, m_b = 4'd0, m_op = 4'd0, m_imm = 4'd0;
   logic       m_ld = 1'b0;
   logic [1:0] m_rd = 2'd0;
   logic [4:0] m_rsp = 5'd0;
   logic       m_flag = 1'b0;
   int         m_phase = 0;
   logic [4:0] m_res;
   bit         chk_on = 1'b0;

   assign m_res = alu_fn(m_a, m_b, m_op);

   always @(posedge clk) begin
      if (rst) begin
         m_phase <= 0;
         for (int i = 0; i < 4; i++) m_rf[i] <= 4'd0;
         m_a    <= 4'd0;
         m_b    <= 4'd0;
         m_op   <= 4'd0;
         m_rsp  <= 5'd0;
         m_flag <= 1'b0;
      end else if (m_phase == 0) begin
         if (cmd_valid) begin
            m_a     <= m_rf[cmd_ra];
            m_b     <= m_rf[cmd_rb];
            m_op    <= cmd_op;
            m_ld    <= cmd_ld;
            m_rd    <= cmd_rd;
            m_imm   <= cmd_imm;
            m_phase <= 1;
         end
      end else if (m_phase == 1) begin
         if (m_ld) begin
            m_rf[m_rd] <= m_imm;
            m_rsp      <= {1'b0, m_imm};
         end else begin
            m_rf[m_rd] <= m_res[3:0];
            m_rsp      <= m_res;
            if (FLAG_EN) m_flag <= m_res[4];
         end
         m_phase <= 2;
      end else begin
         if (rsp_ready) m_phase <= 0;
      end
      chk_on <= 1'b1;
   end

   // Compare every output on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (chk_on) begin
         check("cmd_ready", cmd_ready, (m_phase == 0) && !rst);
         check("rsp_valid", rsp_valid, m_phase == 2);
         check("alu_a",     alu_a,     m_a);
         check("alu_b",     alu_b,     m_b);
         check("alu_op",    alu_op,    m_op);
         check("rsp_data",  rsp_data,  m_rsp);
         check("flag",      flag,      m_flag);
      end
   end

   // ------------------------------------------------------------------------
   // Directed helpers. All drive happens 1 time unit after a rising edge.
   // ------------------------------------------------------------------------
   task automatic set_cmd(input bit ld, input logic [3:0] op, input logic [1:0] ra,
                          input logic [1:0] rb, input logic [1:0] rd, input logic [3:0] imm);
      cmd_ld  = ld;
      cmd_op  = op;
      cmd_ra  = ra;
      cmd_rb  = rb;
      cmd_rd  = rd;
      cmd_imm = imm;
   endtask

   // Presents a command and returns 1 time unit after the accepting edge.
   task automatic send(input string name, input bit ld, input logic [3:0] op,
                       input logic [1:0] ra, input logic [1:0] rb, input logic [1:0] rd,
                       input logic [3:0] imm);
      bit got = 1'b0;
      set_cmd(ld, op, ra, rb, rd, imm);
      cmd_valid = 1'b1;
      for (int n = 0; n < 20 && !got; n++) begin
         @(negedge clk);
         got = cmd_ready;
         @(posedge clk);
         #1;
      end
      cmd_valid = 1'b0;
      check({name, "_accepted"}, got, 1'b1);
   endtask

   // Full command: operands seen during ISSUE, response exactly one cycle
   // after acceptance, then acknowledged.
   task automatic do_cmd(input string name, input bit ld, input logic [3:0] op,
                         input logic [1:0] ra, input logic [1:0] rb, input logic [1:0] rd,
                         input logic [3:0] imm, input logic [3:0] exp_a,
                         input logic [3:0] exp_b, input logic [4:0] exp_rsp);
      send(name, ld, op, ra, rb, rd, imm);
      @(negedge clk);
      check({name, "_issue_a"}, alu_a, exp_a);
      check({name, "_issue_b"}, alu_b, exp_b);
      check({name, "_issue_novalid"}, rsp_valid, 1'b0);
      @(negedge clk);
      check({name, "_rsp_valid"}, rsp_valid, 1'b1);
      check({name, "_rsp_data"}, rsp_data, exp_rsp);
      @(posedge clk);
      #1 rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
   endtask

   initial begin
      // Reset.
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_cmd_ready_low", cmd_ready, 1'b0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("reset_cmd_ready_high", cmd_ready, 1'b1);
      check("reset_rsp_data", rsp_data, 5'd0);
      check("reset_flag", flag, 1'b0);
      @(posedge clk);
      #1;

      // Loads, ALU ops, flag behaviour, and same-register read-before-write.
      do_cmd("ld_r0_9",   1'b1, 4'b0000, 2'd0, 2'd0, 2'd0, 4'd9, 4'd0, 4'd0, 5'b01001);
      do_cmd("ld_r1_7",   1'b1, 4'b0000, 2'd0, 2'd0, 2'd1, 4'd7, 4'd9, 4'd9, 5'b00111);
      do_cmd("add_r0_r1", 1'b0, 4'b0000, 2'd0, 2'd1, 2'd2, 4'd0, 4'd9, 4'd7, 5'b10000);
      check("add_flag", flag, FLAG_EN);
      do_cmd("sub_r1_r0", 1'b0, 4'b0001, 2'd1, 2'd0, 2'd3, 4'd0, 4'd7, 4'd9, 5'b11110);
      do_cmd("ld_keeps_flag", 1'b1, 4'b0000, 2'd0, 2'd1, 2'd2, 4'd5, 4'd9, 4'd7, 5'b00101);
      check("ld_flag_unchanged", flag, FLAG_EN);
      do_cmd("eq_r0_r0",  1'b0, 4'b1100, 2'd0, 2'd0, 2'd2, 4'd0, 4'd9, 4'd9, 5'b00001);
      do_cmd("ld_r2_15",  1'b1, 4'b0000, 2'd0, 2'd0, 2'd2, 4'd15, 4'd9, 4'd9, 5'b01111);
      do_cmd("inc_carry", 1'b0, 4'b0010, 2'd2, 2'd0, 2'd2, 4'd0, 4'd15, 4'd9, 5'b10000);
      check("inc_flag_set", flag, FLAG_EN);
      do_cmd("gt_r1_r0",  1'b0, 4'b1111, 2'd1, 2'd0, 2'd2, 4'd0, 4'd7, 4'd9, 5'b00000);
      check("gt_flag_cleared", flag, 1'b0);
      do_cmd("eq_r3_r3",  1'b0, 4'b1100, 2'd3, 2'd3, 2'd2, 4'd0, 4'd14, 4'd14, 5'b00001);
      do_cmd("add_rd_src", 1'b0, 4'b0000, 2'd2, 2'd2, 2'd2, 4'd0, 4'd1, 4'd1, 5'b00010);
      do_cmd("add_r2_r1", 1'b0, 4'b0000, 2'd2, 2'd1, 2'd0, 4'd0, 4'd2, 4'd7, 5'b01001);

      // Minimum spacing: rsp_ready high from the ISSUE cycle, next command
      // waiting, accepted three edges after the first.
      send("spacing_first", 1'b1, 4'b0000, 2'd0, 2'd0, 2'd3, 4'd3);
      rsp_ready = 1'b1;
      set_cmd(1'b0, 4'b0000, 2'd3, 2'd3, 2'd1, 4'd0);
      cmd_valid = 1'b1;
      @(negedge clk);
      check("spacing_issue_ready", cmd_ready, 1'b0);
      @(negedge clk);
      check("spacing_rsp", rsp_data, 5'b00011);
      check("spacing_resp_ready", cmd_ready, 1'b0);
      @(posedge clk);
      #1;
      @(negedge clk);
      check("spacing_idle_ready", cmd_ready, 1'b1);
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      rsp_ready = 1'b0;
      @(negedge clk);
      check("spacing_second_a", alu_a, 4'd3);
      check("spacing_second_b", alu_b, 4'd3);
      @(negedge clk);
      check("spacing_second_rsp", rsp_data, 5'b00110);
      @(posedge clk);
      #1 rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;

      // Backpressure: response held for 4 cycles with a command waiting.
      send("bp_first", 1'b1, 4'b0000, 2'd0, 2'd0, 2'd1, 4'd12);
      @(posedge clk);
      #1;
      set_cmd(1'b0, 4'b0000, 2'd1, 2'd1, 2'd0, 4'd0);
      cmd_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("bp_rsp_stable", rsp_data, 5'b01100);
         check("bp_rsp_valid", rsp_valid, 1'b1);
         check("bp_cmd_ready", cmd_ready, 1'b0);
         @(posedge clk);
         #1;
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
      @(negedge clk);
      check("bp_release_ready", cmd_ready, 1'b1);
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      @(negedge clk);
      check("bp_second_a", alu_a, 4'd12);
      @(negedge clk);
      check("bp_second_rsp", rsp_data, 5'b11000);
      @(posedge clk);
      #1 rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;

      // Reset while a command is in ISSUE.
      send("rst_issue", 1'b0, 4'b0000, 2'd0, 2'd1, 2'd3, 4'd0);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_issue_rsp_valid", rsp_valid, 1'b0);
      check("rst_issue_cmd_ready", cmd_ready, 1'b1);
      check("rst_issue_alu_a", alu_a, 4'd0);
      check("rst_issue_rsp_data", rsp_data, 5'd0);
      @(posedge clk);
      #1;
      do_cmd("post_rst_r0_r3", 1'b0, 4'b0000, 2'd0, 2'd3, 2'd1, 4'd0, 4'd0, 4'd0, 5'b00000);
      do_cmd("post_rst_r1_r2", 1'b0, 4'b0001, 2'd1, 2'd2, 2'd1, 4'd0, 4'd0, 4'd0, 5'b00000);

      // Randomized traffic, checked by the model every cycle.
      for (int c = 0; c < 4000; c++) begin
         @(posedge clk);
         #1;
         set_cmd(1'($urandom), 4'($urandom), 2'($urandom), 2'($urandom),
                 2'($urandom), 4'($urandom));
         cmd_valid = ($urandom % 3) != 0;
         rsp_ready = ($urandom % 2) != 0;
         rst       = ($urandom % 250) == 0;
      end
      @(posedge clk);
      #1;
      rst       = 1'b0;
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
